// File: rtl/vector_register_file_if.sv
`default_nettype none
// ============================================================================
//  Module   : vector_register_file_if
//  Purpose  : Write, read, scoreboard and clear signals of the SIMD vector
//             register file, bundled with master/slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface vector_register_file_if #(
    parameter int LANE_W   = 8,
    parameter int LANES    = 4,
    parameter int SEL_BITS = 3
);
    logic                      wrEn;
    logic [SEL_BITS-1:0]       wrSel;
    logic [LANES-1:0]          wrMask;
    logic                      wrBroadcast;
    logic [LANES*LANE_W-1:0]   dataIn;
    logic [SEL_BITS-1:0]       rSel1;
    logic [SEL_BITS-1:0]       rSel2;
    logic [LANES*LANE_W-1:0]   reg1Out;
    logic [LANES*LANE_W-1:0]   reg2Out;
    logic                      resvEn;
    logic [SEL_BITS-1:0]       resvSel;
    logic                      busy1;
    logic                      busy2;
    logic                      resvErr;
    logic                      clrReq;
    logic                      clrBusy;

    // Datapath master (issue logic) drives requests and selects
    modport master (
        output wrEn, wrSel, wrMask, wrBroadcast, dataIn,
        output rSel1, rSel2, resvEn, resvSel, clrReq,
        input  reg1Out, reg2Out, busy1, busy2, resvErr, clrBusy
    );

    // Register file side
    modport slave (
        input  wrEn, wrSel, wrMask, wrBroadcast, dataIn,
        input  rSel1, rSel2, resvEn, resvSel, clrReq,
        output reg1Out, reg2Out, busy1, busy2, resvErr, clrBusy
    );
endinterface
`default_nettype wire

// File: rtl/vector_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : vector_register_file
//  Purpose  : SIMD vector register file with two bypassed combinational read
//             ports, masked/broadcast write port, pending-write scoreboard
//             and a one-register-per-cycle sequential clear engine.
//  Revision : 1.0 - initial release
// ============================================================================
module vector_register_file #(
    parameter int LANE_W   = 8,
    parameter int LANES    = 4,
    parameter int REGS     = 8,
    parameter int SEL_BITS = 3
) (
    input  wire logic               clk,
    input  wire logic               rst,    // asynchronous, active-low
    vector_register_file_if.slave   bus
);
    localparam int                  c_DW    = LANES * LANE_W;
    localparam logic [SEL_BITS:0]   c_NREGS = (SEL_BITS + 1)'(REGS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SEL_BITS-1:0]    r_clrIdx;
    logic [c_DW-1:0]        r_regs [REGS];
    logic [REGS-1:0]        r_pending;
    logic                   r_resvErr;

    logic [c_DW-1:0]        w_wdata;
    logic                   w_idle;
    logic                   w_wrValid;
    logic                   w_fullMask;
    logic                   w_resvValid;
    logic                   w_bypassEn;
    logic                   w_lastIdx;

    function automatic logic in_range(input logic [SEL_BITS-1:0] sel);
        return ({1'b0, sel} < c_NREGS);
    endfunction

    // Storage view of one register with the same-cycle write merged per lane;
    // everything reads as zero while reset is held.
    function automatic logic [c_DW-1:0] read_port(input logic [SEL_BITS-1:0] sel);
        logic [c_DW-1:0] v;
        v = '0;
        if (rst && in_range(sel)) begin
            v = r_regs[sel];
            for (int i = 0; i < LANES; i++) begin
                if (w_bypassEn && (bus.wrSel == sel) && bus.wrMask[i])
                    v[i*LANE_W +: LANE_W] = w_wdata[i*LANE_W +: LANE_W];
            end
        end
        return v;
    endfunction

    // A full write to the register being read hides its pending bit, unless
    // the same register is re-reserved in this cycle.
    function automatic logic busy_port(input logic [SEL_BITS-1:0] sel);
        logic clearing;
        clearing = w_wrValid && w_fullMask && (bus.wrSel == sel) &&
                   !(w_resvValid && (bus.resvSel == sel));
        return rst && in_range(sel) && r_pending[sel] && !clearing;
    endfunction

    // Write data selection, request qualification and read ports
    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            w_wdata[i*LANE_W +: LANE_W] = bus.wrBroadcast ? bus.dataIn[LANE_W-1:0]
                                                          : bus.dataIn[i*LANE_W +: LANE_W];
        end
        w_idle      = (r_state == ST_IDLE);
        w_wrValid   = bus.wrEn && in_range(bus.wrSel) && w_idle;
        w_fullMask  = &bus.wrMask;
        w_resvValid = bus.resvEn && in_range(bus.resvSel) && w_idle;
        w_bypassEn  = w_wrValid && rst;
        w_lastIdx   = ({1'b0, r_clrIdx} == (c_NREGS - 1'b1));
        bus.reg1Out = read_port(bus.rSel1);
        bus.reg2Out = read_port(bus.rSel2);
        bus.busy1   = busy_port(bus.rSel1);
        bus.busy2   = busy_port(bus.rSel2);
        bus.resvErr = r_resvErr;
        bus.clrBusy = (r_state == ST_CLEAR);
    end

    // Clear engine state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Clear engine next-state: one register per cycle, exit after the last
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.clrReq) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (w_lastIdx)  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Clear index: restart on request, advance while clearing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       r_clrIdx <= '0;
        else if (w_idle && bus.clrReq)  r_clrIdx <= '0;
        else if (!w_idle)               r_clrIdx <= r_clrIdx + 1'b1;
    end

    // Register storage: clear engine has priority, else masked lane writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < REGS; r++) r_regs[r] <= '0;
        end else if (!w_idle) begin
            r_regs[r_clrIdx] <= '0;
        end else if (w_wrValid) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wrMask[i])
                    r_regs[bus.wrSel][i*LANE_W +: LANE_W] <= w_wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    // Scoreboard: reservation is applied last so it wins over a full write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
        end else if (!w_idle) begin
            r_pending[r_clrIdx] <= 1'b0;
        end else begin
            if (w_wrValid && w_fullMask) r_pending[bus.wrSel]   <= 1'b0;
            if (w_resvValid)             r_pending[bus.resvSel] <= 1'b1;
        end
    end

    // Double-reservation error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_resvErr <= 1'b0;
        else      r_resvErr <= w_resvValid && r_pending[bus.resvSel];
    end
endmodule
`default_nettype wire

// File: tb/tb_vector_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_register_file
//  Purpose  : Self-checking bench: directed vector table, clear/reset
//             sequences, then random traffic against a lane-array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vector_register_file;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vector_register_file_if #(.LANE_W(8), .LANES(4), .SEL_BITS(3)) bus ();

    vector_register_file #(.LANE_W(8), .LANES(4), .REGS(8), .SEL_BITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        we;
        logic [2:0]  ws;
        logic [3:0]  wm;
        logic        bc;
        logic [31:0] din;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic        re;
        logic [2:0]  rs;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
        logic        eerr;
    } vec_t;

    vec_t tv [19];

    // Reference model: registers as byte lanes, pending flags, clear countdown
    logic [7:0] m_reg [8][4];
    bit         m_pend [8];
    int         m_clr_left;
    int         m_clr_idx;
    bit         m_err;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(logic we, logic [2:0] ws, logic [3:0] wm, logic bc,
                                logic [31:0] din, logic [2:0] s1, logic [2:0] s2,
                                logic re, logic [2:0] rs, logic [31:0] e1, logic [31:0] e2,
                                logic eb1, logic eb2, logic eerr);
        vec_t v;
        v.we = we; v.ws = ws; v.wm = wm; v.bc = bc; v.din = din;
        v.s1 = s1; v.s2 = s2; v.re = re; v.rs = rs;
        v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic we, input logic [2:0] ws, input logic [3:0] wm,
                          input logic bc, input logic [31:0] din, input logic [2:0] s1,
                          input logic [2:0] s2, input logic re, input logic [2:0] rs,
                          input logic clr);
        bus.wrEn = we; bus.wrSel = ws; bus.wrMask = wm; bus.wrBroadcast = bc;
        bus.dataIn = din; bus.rSel1 = s1; bus.rSel2 = s2;
        bus.resvEn = re; bus.resvSel = rs; bus.clrReq = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_wlane(int i);
        return bus.wrBroadcast ? bus.dataIn[7:0] : bus.dataIn[i*8 +: 8];
    endfunction

    function automatic logic [31:0] m_read(logic [2:0] sel);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            if (m_clr_left == 0 && bus.wrEn && bus.wrSel == sel && bus.wrMask[i])
                v[i*8 +: 8] = m_wlane(i);
            else
                v[i*8 +: 8] = m_reg[sel][i];
        end
        return v;
    endfunction

    function automatic logic m_busy(logic [2:0] sel);
        logic hide;
        hide = (m_clr_left == 0) && bus.wrEn && bus.wrSel == sel && bus.wrMask == 4'hF &&
               !(bus.resvEn && bus.resvSel == sel);
        return m_pend[sel] && !hide;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 8; r++) begin
            m_pend[r] = 1'b0;
            for (int i = 0; i < 4; i++) m_reg[r][i] = 8'h00;
        end
        m_clr_left = 0;
        m_clr_idx  = 0;
        m_err      = 1'b0;
    endtask

    // Applies the rules of one clock edge to the model
    task automatic m_edge();
        if (m_clr_left > 0) begin
            for (int i = 0; i < 4; i++) m_reg[m_clr_idx][i] = 8'h00;
            m_pend[m_clr_idx] = 1'b0;
            m_clr_idx++;
            m_clr_left--;
            m_err = 1'b0;
        end else begin
            m_err = bus.resvEn && m_pend[bus.resvSel];
            if (bus.wrEn) begin
                for (int i = 0; i < 4; i++)
                    if (bus.wrMask[i]) m_reg[bus.wrSel][i] = m_wlane(i);
                if (bus.wrMask == 4'hF) m_pend[bus.wrSel] = 1'b0;
            end
            if (bus.resvEn) m_pend[bus.resvSel] = 1'b1;
            if (bus.clrReq) begin
                m_clr_left = 8;
                m_clr_idx  = 0;
            end
        end
    endtask

    initial begin
        logic [2:0]  rws, rs1, rs2;
        logic [3:0]  rwm;
        // Directed vectors: inputs for one cycle, outputs sampled before the edge
        tv[0]  = mk(1, 1, 4'hF, 0, 32'hFEDCBA98, 1, 0, 0, 0, 32'hFEDCBA98, 32'h0, 0, 0, 0);
        tv[1]  = mk(0, 0, 4'h0, 0, 32'h0,        1, 0, 0, 0, 32'hFEDCBA98, 32'h0, 0, 0, 0);
        tv[2]  = mk(1, 3, 4'hF, 0, 32'h11223344, 3, 1, 0, 0, 32'h11223344, 32'hFEDCBA98, 0, 0, 0);
        tv[3]  = mk(1, 3, 4'h5, 0, 32'hAAAAAAAA, 3, 3, 0, 0, 32'h11AA33AA, 32'h11AA33AA, 0, 0, 0);
        tv[4]  = mk(0, 0, 4'h0, 0, 32'h0,        3, 0, 0, 0, 32'h11AA33AA, 32'h0, 0, 0, 0);
        tv[5]  = mk(1, 3, 4'hF, 1, 32'h1234565C, 3, 0, 0, 0, 32'h5C5C5C5C, 32'h0, 0, 0, 0);
        tv[6]  = mk(0, 0, 4'h0, 0, 32'h0,        3, 2, 0, 0, 32'h5C5C5C5C, 32'h0, 0, 0, 0);
        tv[7]  = mk(0, 0, 4'h0, 0, 32'h0,        2, 0, 1, 2, 32'h0,        32'h0, 0, 0, 0);
        tv[8]  = mk(0, 0, 4'h0, 0, 32'h0,        2, 0, 0, 0, 32'h0,        32'h0, 1, 0, 0);
        tv[9]  = mk(1, 2, 4'h3, 0, 32'hDEADBEEF, 2, 0, 0, 0, 32'h0000BEEF, 32'h0, 1, 0, 0);
        tv[10] = mk(0, 0, 4'h0, 0, 32'h0,        2, 0, 0, 0, 32'h0000BEEF, 32'h0, 1, 0, 0);
        tv[11] = mk(1, 2, 4'hF, 0, 32'h01020304, 2, 0, 0, 0, 32'h01020304, 32'h0, 0, 0, 0);
        tv[12] = mk(0, 0, 4'h0, 0, 32'h0,        2, 0, 0, 0, 32'h01020304, 32'h0, 0, 0, 0);
        tv[13] = mk(0, 0, 4'h0, 0, 32'h0,        4, 0, 1, 4, 32'h0,        32'h0, 0, 0, 0);
        tv[14] = mk(0, 0, 4'h0, 0, 32'h0,        4, 0, 1, 4, 32'h0,        32'h0, 1, 0, 0);
        tv[15] = mk(0, 0, 4'h0, 0, 32'h0,        4, 0, 0, 0, 32'h0,        32'h0, 1, 0, 1);
        tv[16] = mk(0, 0, 4'h0, 0, 32'h0,        4, 0, 0, 0, 32'h0,        32'h0, 1, 0, 0);
        tv[17] = mk(1, 5, 4'hF, 0, 32'h55555555, 5, 4, 1, 5, 32'h55555555, 32'h0, 0, 1, 0);
        tv[18] = mk(0, 0, 4'h0, 0, 32'h0,        5, 4, 0, 0, 32'h55555555, 32'h0, 1, 1, 0);

        // Reset state, with a write request present to show bypass is suppressed
        set_in(1, 1, 4'hF, 0, 32'hFFFFFFFF, 1, 1, 1, 1, 0);
        @(negedge clk);
        chk("reset reg1Out", bus.reg1Out, 32'h0);
        chk("reset reg2Out", bus.reg2Out, 32'h0);
        chk("reset busy",    {30'b0, bus.busy1, bus.busy2}, 32'h0);
        chk("reset resvErr", {31'b0, bus.resvErr}, 32'h0);
        chk("reset clrBusy", {31'b0, bus.clrBusy}, 32'h0);
        set_in(0, 0, 4'h0, 0, 32'h0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();

        for (int n = 0; n < 19; n++) begin
            set_in(tv[n].we, tv[n].ws, tv[n].wm, tv[n].bc, tv[n].din,
                   tv[n].s1, tv[n].s2, tv[n].re, tv[n].rs, 0);
            @(negedge clk);
            chk($sformatf("vec%0d reg1Out", n), bus.reg1Out, tv[n].e1);
            chk($sformatf("vec%0d reg2Out", n), bus.reg2Out, tv[n].e2);
            chk($sformatf("vec%0d busy1", n),   {31'b0, bus.busy1}, {31'b0, tv[n].eb1});
            chk($sformatf("vec%0d busy2", n),   {31'b0, bus.busy2}, {31'b0, tv[n].eb2});
            chk($sformatf("vec%0d resvErr", n), {31'b0, bus.resvErr}, {31'b0, tv[n].eerr});
            tick();
        end

        // Clear: fill all registers, then clear while trying to write/reserve
        for (int r = 0; r < 8; r++) begin
            set_in(1, 3'(r), 4'hF, 0, {4{8'hA0 + 8'(r)}}, 0, 0, 0, 0, 0);
            tick();
        end
        set_in(0, 0, 4'h0, 0, 32'h0, 7, 0, 0, 0, 1);
        @(negedge clk);
        chk("clrReq cycle clrBusy", {31'b0, bus.clrBusy}, 32'h0);
        tick();
        for (int k = 0; k < 8; k++) begin
            set_in(1, 0, 4'hF, 0, 32'hFFFFFFFF, 7, 0, 1, 3, 1);
            @(negedge clk);
            chk($sformatf("clear%0d clrBusy", k), {31'b0, bus.clrBusy}, 32'h1);
            chk($sformatf("clear%0d reg7 old", k), bus.reg1Out, 32'hA7A7A7A7);
            chk($sformatf("clear%0d reg0", k), bus.reg2Out, (k == 0) ? 32'hA0A0A0A0 : 32'h0);
            tick();
        end
        for (int r = 0; r < 8; r++) begin
            set_in(0, 0, 4'h0, 0, 32'h0, 3'(r), 3'(r), 0, 0, 0);
            @(negedge clk);
            chk($sformatf("postclear reg%0d", r), bus.reg1Out, 32'h0);
            chk($sformatf("postclear busy%0d", r), {30'b0, bus.busy1, bus.busy2}, 32'h0);
            chk($sformatf("postclear clrBusy%0d", r), {31'b0, bus.clrBusy}, 32'h0);
            tick();
        end

        // Reset during the fourth clear cycle aborts the clear
        set_in(1, 7, 4'hF, 0, 32'h77777777, 0, 0, 0, 0, 0); tick();
        set_in(1, 2, 4'hF, 0, 32'h22222222, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 4'h0, 0, 32'h0, 7, 2, 0, 0, 1);        tick();
        set_in(0, 0, 4'h0, 0, 32'h0, 7, 2, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("midclear%0d clrBusy", k), {31'b0, bus.clrBusy}, 32'h1);
            tick();
        end
        #2 rst = 1'b0;
        #1;
        chk("async reset clrBusy", {31'b0, bus.clrBusy}, 32'h0);
        chk("in-reset reg7", bus.reg1Out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("after reset reg7", bus.reg1Out, 32'h0);
        chk("after reset reg2", bus.reg2Out, 32'h0);
        chk("after reset clrBusy", {31'b0, bus.clrBusy}, 32'h0);
        tick();

        // Random traffic against the model
        rst = 1'b0;
        set_in(0, 0, 4'h0, 0, 32'h0, 0, 0, 0, 0, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        for (int n = 0; n < 600; n++) begin
            rws = 3'($urandom_range(0, 7));
            rwm = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            rs1 = ($urandom_range(0, 1) == 0) ? rws : 3'($urandom_range(0, 7));
            rs2 = 3'($urandom_range(0, 7));
            set_in(1'($urandom), rws, rwm, ($urandom_range(0, 3) == 0), $urandom,
                   rs1, rs2, ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                   ($urandom_range(0, 59) == 0));
            @(negedge clk);
            chk("rand reg1Out", bus.reg1Out, m_read(bus.rSel1));
            chk("rand reg2Out", bus.reg2Out, m_read(bus.rSel2));
            chk("rand busy1",   {31'b0, bus.busy1},   {31'b0, m_busy(bus.rSel1)});
            chk("rand busy2",   {31'b0, bus.busy2},   {31'b0, m_busy(bus.rSel2)});
            chk("rand resvErr", {31'b0, bus.resvErr}, {31'b0, m_err});
            chk("rand clrBusy", {31'b0, bus.clrBusy}, {31'b0, (m_clr_left > 0)});
            @(posedge clk);
            m_edge();
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vector_register_file.md
# vector_register_file

Parametrised SIMD vector register file: the lane-parallel successor to the scalar register file, feeding the vector ALU in the SIMD processor datapath. It provides:
- `REGS` registers of `LANES` × `LANE_W` bits, with two combinational read ports and one write port.
- Per-lane write masking, scalar-broadcast writes and same-cycle write-through bypass.
- A pending-write scoreboard for hazard detection.
- A multi-cycle sequential clear engine.

## Interface
- `LANE_W`, 8, bits per lane
- `LANES`, 4, lanes per vector register
- `REGS`, 8, number of vector registers
- `SEL_BITS`, 3, register select width; `REGS` must be ≤ 2^`SEL_BITS`
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `wrEn`  in  1  write enable
- `wrSel`  in  `SEL_BITS`  destination register
- `wrMask`  in  `LANES`  per-lane write enable; bit i gates lane i
- `wrBroadcast`  in  1  replicate `dataIn` lane 0 into every lane
- `dataIn`  in  `LANES*LANE_W`  write data; lane i at [i*`LANE_W` +: `LANE_W`]
- `rSel1`, `rSel2`  in  `SEL_BITS`  read selects
- `reg1Out`, `reg2Out`  out  `LANES*LANE_W`  read data
- `resvEn`  in  1  reserve a register as pending-write
- `resvSel`  in  `SEL_BITS`  register to reserve
- `busy1`, `busy2`  out  1  pending flag for `rSel1` / `rSel2`
- `resvErr`  out  1  registered one-cycle pulse: reservation hit an already-pending register
- `clrReq`  in  1  start sequential clear of all registers
- `clrBusy`  out  1  clear engine active

## Operation
- Write data: `wdata` = `wrBroadcast` ? {`LANES`{`dataIn`[`LANE_W`-1:0]}} : `dataIn`.
- Write: on edge with `wrEn`, lane i of reg[`wrSel`] takes `wdata` lane i only where `wrMask`[i]=1. Other lanes hold.
- Out-of-range selects (≥ `REGS`):
  - Writes and reservations are dropped.
  - Reads return 0; `busy` reads 0.
- Reads are combinational from storage, with per-lane bypass: if `wrEn` and `wrSel`==`rSelN` and `wrMask`[i], lane i of `regNOut` = `wdata` lane i in the same cycle.
- Scoreboard, one pending bit per register:
  - `resvEn` sets pending[`resvSel`].
  - A write with `wrMask` all-ones clears pending[`wrSel`]. A partial-mask write does not clear it.
  - Same edge, same register, reserve and clear: set wins.
  - `resvEn` to an already-pending register: pending stays 1 and `resvErr` pulses the next cycle.
- `busyN` = pending[`rSelN`] AND NOT (`wrEn` AND `wrSel`==`rSelN` AND `wrMask` all-ones AND NOT same-cycle reservation of `rSelN`).
- Clear FSM, states IDLE and CLEAR, counter `clrIdx`:
  - IDLE → CLEAR on `clrReq`; `clrIdx` ← 0.
  - CLEAR: each edge zeroes reg[`clrIdx`] and pending[`clrIdx`], then increments `clrIdx`. At `clrIdx`==`REGS`-1 it clears that register and returns to IDLE.
  - `clrBusy` = (state==CLEAR).
  - While CLEAR: `wrEn`, `resvEn` and `clrReq` are ignored, and bypass is disabled. Reads return the current storage, so some registers may already be cleared and others not yet.

## Timing
- Reset (`rst`=0, asynchronous):
  - All registers 0, all pending 0, state IDLE, `clrIdx` 0.
  - `resvErr` 0, `clrBusy` 0.
  - `reg1Out`/`reg2Out` 0 and `busy1`/`busy2` 0; bypass is suppressed while in reset.
- Reset asserted mid-clear aborts the clear immediately. Release resumes in IDLE.
- Write latency: 1 edge to storage, 0 cycles via bypass.
- Reservation visible on `busy` the cycle after `resvEn`.
- Clear occupies exactly `REGS` cycles: `clrBusy` high from the edge after `clrReq` for `REGS` cycles.
- `resvErr` is high for exactly one cycle per offending reservation.

## Test plan
- Reset, then write reg1 = 0xFE_DC_BA_98 with full mask; same-cycle `rSel1`=1 reads 0xFEDCBA98 via bypass; next cycle it reads from storage; `reg2Out` (rSel2=0) = 0.
- Reg3 = 0x11223344; then write 0xAAAAAAAA with `wrMask`=4'b0101 → reg3 reads 0x11AA33AA. Then `wrBroadcast` with `dataIn` lane0=0x5C and mask 1111 → reg3 reads 0x5C5C5C5C.
- Scoreboard:
  - `resvEn` reg2 → next cycle `busy1`=1 (`rSel1`=2).
  - Partial-mask write to reg2 → `busy1` stays 1.
  - Full-mask write → `busy1` drops in the write cycle; pending clear after the edge.
- Conflicts:
  - Reserve reg4 twice on consecutive cycles → `resvErr` high for one cycle.
  - Reserve reg5 and full-write reg5 on the same edge → pending[5]=1.
- Clear:
  - Fill all 8 registers, pulse `clrReq` → `clrBusy` high for 8 cycles.
  - A `wrEn` to reg0 during clear has no effect.
  - Afterwards all reads are 0 and all busy flags 0.
- Mid-clear reset: assert `rst`=0 at the fourth clear cycle → `clrBusy` drops asynchronously and all registers read 0 after release.
